// File: rtl/arbitro_rr_mux21_pkg.sv
// Shared types and defaults for the two-requester
// round-robin arbiter feeding a registered 2:1 mux.
package arbitro_pkg;

  localparam int COUNT_W_DEF = 7;
  localparam int DATA_W_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

endpackage

// File: rtl/arbitro_rr_mux21_if.sv
// Requester/downstream handshake bundle.
// slave = the arbiter, master = its environment.
interface arbitro_rr_mux21_if #(
  parameter int DATA_W = 2
);

  logic              valid0;
  logic              valid1;
  logic [DATA_W-1:0] data_in0;
  logic [DATA_W-1:0] data_in1;
  logic              ready0;
  logic              ready1;
  logic              ready_out;
  logic              valid_out;
  logic [DATA_W-1:0] data_out;
  logic              selector;

  modport slave (
    input  valid0, valid1,
    input  data_in0, data_in1,
    input  ready_out,
    output ready0, ready1,
    output valid_out, data_out, selector
  );

  modport master (
    output valid0, valid1,
    output data_in0, data_in1,
    output ready_out,
    input  ready0, ready1,
    input  valid_out, data_out, selector
  );

endinterface

// File: rtl/arbitro_rr_mux21_mux.sv
// 2:1 data mux with an enable-gated output register;
// the select used for the last load is kept alongside.
module mux21_reg #(
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sel,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] q,
  output logic              sel_q
);

  logic [DATA_W-1:0] d_mux;

  assign d_mux = sel ? d1 : d0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      sel_q <= 1'b0;
    end else if (en) begin
      q     <= d_mux;
      sel_q <= sel;
    end
  end

endmodule

// File: rtl/arbitro_rr_mux21.sv
// Round-robin arbiter for two requesters into a
// registered output slot, with saturating grant counters.
import arbitro_pkg::*;

module arbitro_rr_mux21 #(
  parameter int COUNT_W = COUNT_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               cnt_clear,
  output logic [COUNT_W-1:0] grant_cnt0,
  output logic [COUNT_W-1:0] grant_cnt1,
  arbitro_rr_mux21_if.slave  bus
);

  state_t state, state_n;
  logic   last_grant;
  logic   load_en;
  logic   gnt_vld;
  logic   gnt;
  logic   xfer;
  logic   xfer0;
  logic   xfer1;

  // last_grant resets to 1 so requester 0 wins the first tie
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = 1'b0;
    unique case (1'b1)
      bus.valid0 && bus.valid1: begin
        gnt_vld = 1'b1;
        gnt     = ~last_grant;
      end
      bus.valid0 && !bus.valid1: begin
        gnt_vld = 1'b1;
        gnt     = 1'b0;
      end
      !bus.valid0 && bus.valid1: begin
        gnt_vld = 1'b1;
        gnt     = 1'b1;
      end
      default: ;
    endcase
  end

  assign load_en = !bus.valid_out || bus.ready_out;
  assign xfer    = reset_L && load_en && gnt_vld;
  assign xfer0   = xfer && !gnt;
  assign xfer1   = xfer && gnt;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (xfer)         state_n = gnt ? OWN1 : OWN0;
    else if (load_en) state_n = IDLE;
  end

  always_comb begin
    bus.valid_out = (state != IDLE);
    bus.ready0    = xfer0;
    bus.ready1    = xfer1;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)  last_grant <= 1'b1;
    else if (xfer) last_grant <= gnt;
  end

  // clear takes priority over a same-cycle increment
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (cnt_clear) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (xfer0 && grant_cnt0 != '1)
        grant_cnt0 <= grant_cnt0 + 1'b1;
      if (xfer1 && grant_cnt1 != '1)
        grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end

  mux21_reg #(
    .DATA_W (DATA_W)
  ) u_mux (
    .clk   (clk),
    .rst_n (reset_L),
    .en    (xfer),
    .sel   (gnt),
    .d0    (bus.data_in0),
    .d1    (bus.data_in1),
    .q     (bus.data_out),
    .sel_q (bus.selector)
  );

endmodule

// File: tb/tb_arbitro_rr_mux21.sv
// Bench for arbitro_rr_mux21: vector table, directed
// corners and random traffic against a reference model.
module tb_arbitro_rr_mux21;

  localparam int CW  = 7;
  localparam int DW  = 2;
  localparam int MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_L = 1'b0;
  logic          cnt_clear = 1'b0;
  logic [CW-1:0] grant_cnt0;
  logic [CW-1:0] grant_cnt1;

  int checks = 0;
  int errors = 0;

  arbitro_rr_mux21_if #(.DATA_W(DW)) bus ();

  arbitro_rr_mux21 #(
    .COUNT_W (CW),
    .DATA_W  (DW)
  ) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .cnt_clear  (cnt_clear),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
    .bus        (bus)
  );

  always #10 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // reference model: output slot, last winner, per-requester totals
  bit         m_vout = 1'b0;
  logic [1:0] m_data = '0;
  int         m_sel  = 0;
  int         m_last = 1;
  int         m_cnt[2] = '{0, 0};

  function automatic int pick();
    bit         v[2];
    v[0] = bus.valid0;
    v[1] = bus.valid1;
    if (m_vout && !bus.ready_out) return -1;
    for (int k = 1; k <= 2; k++) begin
      int c;
      c = (m_last + k) % 2;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit exp_rdy(input int i);
    return reset_L && (pick() == i);
  endfunction

  always @(negedge reset_L) begin
    m_vout = 1'b0;
    m_data = '0;
    m_sel  = 0;
    m_last = 1;
    m_cnt  = '{0, 0};
  end

  always @(posedge clk) begin
    if (reset_L) begin
      int g;
      g = pick();
      if (g >= 0) begin
        m_data = (g == 0) ? bus.data_in0 : bus.data_in1;
        m_sel  = g;
        m_vout = 1'b1;
        m_last = g;
        if (m_cnt[g] < MAX) m_cnt[g]++;
      end else if (!m_vout || bus.ready_out) begin
        m_vout = 1'b0;
      end
      if (cnt_clear) m_cnt = '{0, 0};
    end
    #1;
    check("ref_data", bus.data_out, m_data);
    check("ref_vout", bus.valid_out, m_vout);
    check("ref_sel", bus.selector, m_sel);
    check("ref_cnt0", grant_cnt0, m_cnt[0]);
    check("ref_cnt1", grant_cnt1, m_cnt[1]);
  end

  always @(negedge clk) begin
    #1;
    check("ref_rdy0", bus.ready0, exp_rdy(0));
    check("ref_rdy1", bus.ready1, exp_rdy(1));
  end

  typedef struct {
    bit v0; bit v1; logic [1:0] d0; logic [1:0] d1; bit ro;
    bit r0; bit r1; bit vo; logic [1:0] dq; bit sq;
  } vec_t;

  vec_t tbl[10];

  task automatic drive(input bit v0, input bit v1,
                       input logic [1:0] d0,
                       input logic [1:0] d1, input bit ro);
    bus.valid0    = v0;
    bus.valid1    = v1;
    bus.data_in0  = d0;
    bus.data_in1  = d1;
    bus.ready_out = ro;
  endtask

  initial begin
    tbl[0] = '{1, 0, 2'd2, 2'd0, 1, 1, 0, 1, 2'd2, 0};
    tbl[1] = '{1, 1, 2'd1, 2'd3, 1, 0, 1, 1, 2'd3, 1};
    tbl[2] = '{1, 1, 2'd1, 2'd3, 1, 1, 0, 1, 2'd1, 0};
    tbl[3] = '{1, 1, 2'd1, 2'd3, 1, 0, 1, 1, 2'd3, 1};
    tbl[4] = '{1, 1, 2'd1, 2'd3, 0, 0, 0, 1, 2'd3, 1};
    tbl[5] = '{1, 1, 2'd2, 2'd0, 0, 0, 0, 1, 2'd3, 1};
    tbl[6] = '{1, 1, 2'd1, 2'd3, 1, 1, 0, 1, 2'd1, 0};
    tbl[7] = '{0, 0, 2'd3, 2'd3, 1, 0, 0, 0, 2'd1, 0};
    tbl[8] = '{0, 1, 2'd3, 2'd2, 0, 0, 1, 1, 2'd2, 1};
    tbl[9] = '{1, 0, 2'd0, 2'd1, 0, 0, 0, 1, 2'd2, 1};

    drive(0, 0, '0, '0, 0);
    repeat (2) @(posedge clk);
    #2;
    check("rst_vout", bus.valid_out, 0);
    check("rst_data", bus.data_out, 0);
    check("rst_sel", bus.selector, 0);
    check("rst_cnt0", grant_cnt0, 0);
    check("rst_cnt1", grant_cnt1, 0);
    @(negedge clk);
    reset_L = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].v0, tbl[i].v1, tbl[i].d0, tbl[i].d1, tbl[i].ro);
      #2;
      check($sformatf("tbl%0d_rdy0", i), bus.ready0, tbl[i].r0);
      check($sformatf("tbl%0d_rdy1", i), bus.ready1, tbl[i].r1);
      @(posedge clk);
      #2;
      check($sformatf("tbl%0d_vout", i), bus.valid_out, tbl[i].vo);
      check($sformatf("tbl%0d_data", i), bus.data_out, tbl[i].dq);
      check($sformatf("tbl%0d_sel", i), bus.selector, tbl[i].sq);
    end
    check("tbl_cnt0", grant_cnt0, 3);
    check("tbl_cnt1", grant_cnt1, 3);

    // saturation, then clear colliding with a transfer
    @(negedge clk);
    drive(1, 0, 2'd1, 2'd0, 1);
    repeat (130) @(negedge clk);
    check("sat_cnt0", grant_cnt0, MAX);
    cnt_clear = 1'b1;
    @(posedge clk);
    #2;
    check("clr_cnt0", grant_cnt0, 0);
    check("clr_cnt1", grant_cnt1, 0);
    check("clr_vout", bus.valid_out, 1);
    @(negedge clk);
    cnt_clear = 1'b0;

    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      drive($urandom_range(0, 1), $urandom_range(0, 1),
            2'($urandom), 2'($urandom), $urandom_range(0, 3) != 0);
      cnt_clear = ($urandom_range(0, 15) == 0);
    end

    // async reset mid-cycle while the slot is full
    @(negedge clk);
    cnt_clear = 1'b0;
    drive(1, 0, 2'd3, 2'd0, 1);
    @(negedge clk);
    drive(1, 1, 2'd1, 2'd2, 0);
    #3;
    reset_L = 1'b0;
    #1;
    check("ar_vout", bus.valid_out, 0);
    check("ar_data", bus.data_out, 0);
    check("ar_sel", bus.selector, 0);
    check("ar_cnt0", grant_cnt0, 0);
    check("ar_cnt1", grant_cnt1, 0);
    check("ar_rdy0", bus.ready0, 0);
    check("ar_rdy1", bus.ready1, 0);
    #1;
    reset_L = 1'b1;
    #1;
    check("tie_rdy0", bus.ready0, 1);
    check("tie_rdy1", bus.ready1, 0);
    @(posedge clk);
    #2;
    check("tie_data", bus.data_out, 1);
    check("tie_sel", bus.selector, 0);
    check("tie_cnt0", grant_cnt0, 1);

    @(negedge clk);
    drive(0, 0, '0, '0, 1);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/arbitro_rr_mux21.md
ARBITRO_RR_MUX21 -- requirements
Module: arbitro_rr_mux21

Interface
REQ-001 Parameter COUNT_W, default 7, width of the per-requester grant counters.
REQ-002 Parameter DATA_W, default 2, width of each data path.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_L  input  1  reset, asynchronous, active-low.
REQ-005 valid0, valid1  input  1 each  requester i presents a word.
REQ-006 data_in0, data_in1  input  DATA_W each  requester payloads.
REQ-007 ready0, ready1  output  1 each  requester i word accepted this cycle (combinational).
REQ-008 ready_out  input  1  downstream accepts data_out this cycle.
REQ-009 valid_out  output  1  data_out holds a valid word (registered).
REQ-010 data_out  output  DATA_W  selected word (registered).
REQ-011 selector  output  1  source of the current data_out: 0 = data_in0, 1 = data_in1 (registered).
REQ-012 cnt_clear  input  1  synchronous clear of both grant counters.
REQ-013 grant_cnt0, grant_cnt1  output  COUNT_W each  words accepted per requester, saturating.

Function
REQ-014 load_en = !valid_out || ready_out; the output register loads only when load_en = 1.
REQ-015 Grant: both valid -> requester != last_grant; only one valid -> that requester; none -> no grant.
REQ-016 ready_i = load_en && grant == i; at most one ready asserted per cycle; ready independent of own valid is not permitted (ready_i = 0 when valid_i = 0).
REQ-017 Transfer on valid_i && ready_i: data_out <= data_in_i, selector <= i, valid_out <= 1, last_grant <= i, grant_cnt_i += 1.
REQ-018 load_en = 1 and no grant -> valid_out <= 0; data_out and selector hold last value.
REQ-019 valid_out = 1 and ready_out = 0 -> data_out, selector, valid_out all hold; no ready asserted.
REQ-020 Latency: word accepted in cycle N appears on data_out in cycle N+1; sustained throughput one word per cycle with ready_out held 1.
REQ-021 State machine IDLE (valid_out = 0), OWN0 (data_out from 0), OWN1 (data_out from 1); next state = OWN<i> on transfer from i, IDLE on load_en without grant, else hold.
REQ-022 Both requesters held valid with ready_out = 1 -> grants strictly alternate 0,1,0,1...
REQ-023 Counters saturate at 2^COUNT_W - 1 (127 default), no wrap.
REQ-024 cnt_clear and a transfer in the same cycle -> counter result 0 (clear wins).
REQ-025 Requester data/valid changes while not granted have no effect on outputs.

Reset
REQ-026 reset_L = 0 immediately forces state IDLE, valid_out 0, data_out 0, selector 0, grant_cnt0/1 0, last_grant 1 (requester 0 wins the first tie).
REQ-027 ready0/ready1 = 0 while reset_L = 0; a word held in data_out at reset assertion is discarded.
REQ-028 Reset release is synchronized to no edge; first grant possible on the first rising clk with reset_L = 1.

Structure
REQ-029 Package arbitro_pkg holds state encoding (IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10) and default COUNT_W/DATA_W constants.
REQ-030 One sub-module mux21_reg: 2:1 DATA_W mux with enable-gated output flop and async active-low reset; arbiter drives its selector and enable.
REQ-031 Counters and grant logic stay in the top module.

Verification
REQ-032 Reset, valid0 = 1 data_in0 = 2'b10, valid1 = 0, ready_out = 1 -> ready0 = 1 that cycle; next cycle data_out = 2'b10, selector = 0, valid_out = 1, grant_cnt0 = 1.
REQ-033 Both valid from reset, data_in0 = 2'b01, data_in1 = 2'b11, ready_out = 1 for 4 cycles -> selector sequence 0,1,0,1; grant_cnt0 = grant_cnt1 = 2.
REQ-034 valid_out = 1, ready_out = 0 for 3 cycles with both valid -> ready0 = ready1 = 0, data_out/selector stable; ready_out = 1 -> next grant goes to requester not last granted.
REQ-035 valid0 held 1 for 130 transfers -> grant_cnt0 stops at 127; cnt_clear pulse with simultaneous transfer -> grant_cnt0 = 0.
REQ-036 reset_L pulsed low between clk edges with valid_out = 1 -> valid_out, data_out, counters 0 before next edge; first tie after release granted to requester 0.
REQ-037 Bench compares data_out against a reference model each posedge and prints an error on mismatch.
